// File: rtl/imem_loader_if.sv
// Loader view of the UART byte stream and the program-memory word write port.
// Bytes are pulse-qualified and the write port has no backpressure.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs UART bytes big-endian into words and writes them from address 0.
// Write issues one cycle after the 4th byte; no backpressure, the byte stream is never stalled.
module imem_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.master       bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_WIDTH:0] word_count
);
  localparam int                    IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0]     IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            byte_idx_q;
  logic [23:0]           asm_q;
  logic [IDLE_W-1:0]     idle_q;

  logic load_entry;
  logic byte_acc;
  logic word_fire;
  logic mem_full;
  logic timeout_hit;

  always_comb begin
    state_d     = state_q;
    load_entry  = 1'b0;
    byte_acc    = 1'b0;
    word_fire   = 1'b0;
    mem_full    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          load_entry = 1'b1;
        end
      end
      S_LOAD: begin
        byte_acc    = bus.rx_valid;
        word_fire   = bus.rx_valid && (byte_idx_q == 2'd3);
        mem_full    = word_fire && (addr_q == ADDR_LAST);
        timeout_hit = !bus.rx_valid && (idle_q == IDLE_LAST);
        if (mem_full || timeout_hit) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      byte_idx_q    <= '0;
      asm_q         <= '0;
      idle_q        <= '0;
      err           <= 1'b0;
      word_count    <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state_q    <= state_d;
      bus.mem_we <= word_fire;

      if (load_entry) begin
        addr_q     <= '0;
        byte_idx_q <= '0;
        idle_q     <= '0;
        word_count <= '0;
        err        <= 1'b0;
      end

      if (byte_acc) begin
        idle_q     <= '0;
        asm_q      <= {asm_q[15:0], bus.rx_data};
        byte_idx_q <= byte_idx_q + 2'd1;
      end else if (state_q == S_LOAD) begin
        idle_q <= idle_q + 1'b1;
      end

      // The last word pins the address at the top so it never wraps to 0.
      if (word_fire) begin
        bus.mem_addr  <= addr_q;
        bus.mem_wdata <= {asm_q, bus.rx_data};
        word_count    <= word_count + 1'b1;
        if (!mem_full) begin
          addr_q <= addr_q + 1'b1;
        end
      end

      if (timeout_hit && (byte_idx_q != 2'd0)) begin
        err <= 1'b1;
      end
    end
  end

  assign busy     = (state_q == S_LOAD);
  assign cpu_hold = busy;
  assign done     = (state_q == S_DONE);
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table-driven loads, hand-written corner sequences and random loads
// checked against a byte-queue model of the expected words, addresses and timing.
module tb_imem_loader;
  localparam int AW  = 14;
  localparam int AWS = 2;
  localparam int TO  = 16;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       start    = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;

  always #5 clock = ~clock;

  imem_loader_if #(.ADDR_WIDTH(AW))  bus ();
  imem_loader_if #(.ADDR_WIDTH(AWS)) bus_s ();

  assign bus.rx_valid   = rx_valid;
  assign bus.rx_data    = rx_data;
  assign bus_s.rx_valid = rx_valid;
  assign bus_s.rx_data  = rx_data;

  logic          cpu_hold, busy, done, err;
  logic [AW:0]   word_count;
  logic          cpu_hold_s, busy_s, done_s, err_s;
  logic [AWS:0]  word_count_s;

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  imem_loader #(.ADDR_WIDTH(AWS), .TIMEOUT(TO)) dut_s (
    .clock(clock), .reset(reset), .start(start), .bus(bus_s),
    .cpu_hold(cpu_hold_s), .busy(busy_s), .done(done_s), .err(err_s), .word_count(word_count_s)
  );

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int nbytes;
    int gap;
    int exp_wc;
    bit exp_err;
  } vec_t;

  wr_t        wq[$];
  wr_t        wq_s[$];
  wr_t        w_mon;
  wr_t        w_mon_s;
  logic [7:0] sent[$];
  int         sent_cyc4[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.mem_we) begin
      w_mon.cyc  = cyc;
      w_mon.addr = 32'(bus.mem_addr);
      w_mon.data = bus.mem_wdata;
      wq.push_back(w_mon);
    end
    if (bus_s.mem_we) begin
      w_mon_s.cyc  = cyc;
      w_mon_s.addr = 32'(bus_s.mem_addr);
      w_mon_s.data = bus_s.mem_wdata;
      wq_s.push_back(w_mon_s);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_start);
    rx_valid = 1'b1;
    rx_data  = b;
    start    = with_start;
    sent.push_back(b);
    if (sent.size() % 4 == 0) sent_cyc4.push_back(cyc);
    tick();
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !done; i++) tick();
  endtask

  task automatic clear_logs();
    wq.delete();
    wq_s.delete();
    sent.delete();
    sent_cyc4.delete();
  endtask

  // Model: word i = bytes 4i..4i+3 big-endian, at address i, one cycle after its 4th byte.
  task automatic verify_load(input string tag, input int exp_wc, input bit exp_err);
    logic [31:0] word;
    check({tag, ".done"}, done, 1);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".cpu_hold"}, cpu_hold, 0);
    check({tag, ".err"}, err, exp_err);
    check({tag, ".word_count"}, word_count, exp_wc);
    check({tag, ".nwrites"}, wq.size(), exp_wc);
    for (int i = 0; i < wq.size() && i < exp_wc && i < sent_cyc4.size(); i++) begin
      word = {sent[4*i], sent[4*i+1], sent[4*i+2], sent[4*i+3]};
      check($sformatf("%s.addr%0d", tag, i), wq[i].addr, i);
      check($sformatf("%s.data%0d", tag, i), wq[i].data, word);
      check($sformatf("%s.cyc%0d", tag, i), wq[i].cyc, sent_cyc4[i] + 1);
    end
  endtask

  task automatic run_load(input int n, input int gap, input bit rand_start);
    clear_logs();
    pulse_start();
    for (int i = 0; i < n; i++) begin
      send_byte(8'($urandom), rand_start && ($urandom_range(0, 3) == 0));
      idle(gap);
    end
    wait_done(4 * TO + 8);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[6];
    logic [7:0] prog[8];
    int         klast;
    int         n;
    int         nb;

    tbl[0] = '{nbytes: 12, gap: 0, exp_wc: 3, exp_err: 1'b0};
    tbl[1] = '{nbytes: 6,  gap: 0, exp_wc: 1, exp_err: 1'b1};
    tbl[2] = '{nbytes: 8,  gap: 1, exp_wc: 2, exp_err: 1'b0};
    tbl[3] = '{nbytes: 0,  gap: 0, exp_wc: 0, exp_err: 1'b0};
    tbl[4] = '{nbytes: 3,  gap: 2, exp_wc: 0, exp_err: 1'b1};
    tbl[5] = '{nbytes: 13, gap: 4, exp_wc: 3, exp_err: 1'b1};
    prog = '{8'h3C, 8'h08, 8'h00, 8'h01, 8'h8D, 8'h09, 8'h00, 8'h04};

    // Reset state
    idle(3);
    check("rst.mem_we", bus.mem_we, 0);
    check("rst.mem_addr", bus.mem_addr, 0);
    check("rst.mem_wdata", bus.mem_wdata, 0);
    check("rst.cpu_hold", cpu_hold, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.err", err, 0);
    check("rst.word_count", word_count, 0);
    reset = 1'b0;
    tick();

    // Bytes while IDLE are ignored
    clear_logs();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    idle(2);
    check("idle_rx.nwrites", wq.size(), 0);
    check("idle_rx.busy", busy, 0);
    check("idle_rx.word_count", word_count, 0);

    // Normal load, bytes every 3 cycles, with exact timeout timing
    clear_logs();
    pulse_start();
    check("normal.busy_after_start", busy, 1);
    check("normal.cpu_hold_after_start", cpu_hold, 1);
    for (int i = 0; i < 8; i++) begin
      klast = cyc;
      send_byte(prog[i], 1'b0);
      if (i != 7) idle(2);
    end
    while (cyc < klast + TO) tick();
    check("normal.done_before_timeout", done, 0);
    check("normal.busy_before_timeout", busy, 1);
    tick();
    check("normal.done_at_timeout", done, 1);
    verify_load("normal", 2, 1'b0);
    if (wq.size() == 2) begin
      check("normal.word0", wq[0].data, 32'h3C080001);
      check("normal.word1", wq[1].data, 32'h8D090004);
    end

    // Table-driven loads
    for (int i = 0; i < 6; i++) begin
      run_load(tbl[i].nbytes, tbl[i].gap, 1'b0);
      verify_load($sformatf("tbl%0d", i), tbl[i].exp_wc, tbl[i].exp_err);
    end

    // Restart from DONE with err set
    clear_logs();
    pulse_start();
    check("restart.err_cleared", err, 0);
    check("restart.done_cleared", done, 0);
    check("restart.busy", busy, 1);
    check("restart.word_count", word_count, 0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    wait_done(4 * TO);
    verify_load("restart", 1, 1'b0);

    // Empty load lasts exactly TIMEOUT cycles
    clear_logs();
    pulse_start();
    n = 0;
    while (busy && n < 4 * TO) begin
      tick();
      n++;
    end
    check("empty.load_cycles", n, TO);
    check("empty.word_count", word_count, 0);
    check("empty.done", done, 1);

    // Reset while the write for the 4th byte is pending
    clear_logs();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    check("midrst.we_issued", bus.mem_we, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst.mem_we", bus.mem_we, 0);
    check("midrst.mem_addr", bus.mem_addr, 0);
    check("midrst.mem_wdata", bus.mem_wdata, 0);
    check("midrst.cpu_hold", cpu_hold, 0);
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.err", err, 0);
    check("midrst.word_count", word_count, 0);
    tick();
    check("midrst.mem_we_after", bus.mem_we, 0);

    // Full memory on the 4-word instance
    clear_logs();
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
    check("full.we_last", bus_s.mem_we, 1);
    check("full.done_with_last", done_s, 1);
    check("full.busy_with_last", busy_s, 0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    wait_done(4 * TO);
    check("full.nwrites", wq_s.size(), 4);
    check("full.word_count", word_count_s, 4);
    check("full.err", err_s, 0);
    check("full.done", done_s, 1);
    for (int i = 0; i < wq_s.size() && i < 4; i++) begin
      check($sformatf("full.addr%0d", i), wq_s[i].addr, i);
      check($sformatf("full.data%0d", i), wq_s[i].data,
            {sent[4*i], sent[4*i+1], sent[4*i+2], sent[4*i+3]});
    end

    // Random loads, some with start pulses injected mid-load
    for (int r = 0; r < 20; r++) begin
      nb = $urandom_range(0, 14);
      run_load(nb, $urandom_range(0, 4), 1'b1);
      verify_load($sformatf("rand%0d", r), nb / 4, (nb % 4) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
